// File: rtl/pc_stall_controller_pkg.sv
// Shared definitions for the PC/fetch/decode stall controller.
// The pipeline registers and the program counter use the same state
// encoding and register-specifier width, so they live here.
package pc_stall_controller_pkg;

  // Register-specifier width used by decode and EX.
  localparam int REG_W = 5;

  // Controller states. The encoding is fixed so that other blocks can
  // decode the debug state bus directly.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MDU_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } state_t;

endpackage

// File: rtl/pc_stall_controller_if.sv
// Bundle of pipeline status inputs and stall/flush controls exchanged
// between the pipeline (master) and the stall controller (slave).
//
// Flow control: imem_valid qualifies the instruction at the fetch output.
// keep_pc is the stall side of the handshake: when it is high the PC and
// fetch stage hold, so the fetched instruction is not consumed that cycle.
// The fetch output is consumed only in a cycle with imem_valid=1 and
// keep_pc=0. mdu_start/mdu_done are single-cycle pulses, not levels.
interface pc_stall_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) ();
  import pc_stall_controller_pkg::*;

  // Pipeline status
  logic             imem_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_mdu;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_load_rt;
  logic             branch_taken;
  logic             mdu_done;

  // Controls back to the pipeline and PC
  logic             keep_pc;
  logic             id_bubble;
  logic             if_flush;
  logic             mdu_start;
  logic             mdu_timeout;
  logic [CNT_W-1:0] stall_count;

  // Current controller state, for observation
  state_t           dbg_state;

  modport master (
    output imem_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu,
           ex_is_load, ex_load_rt, branch_taken, mdu_done,
    input  keep_pc, id_bubble, if_flush, mdu_start, mdu_timeout,
           stall_count, dbg_state
  );

  modport slave (
    input  imem_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu,
           ex_is_load, ex_load_rt, branch_taken, mdu_done,
    output keep_pc, id_bubble, if_flush, mdu_start, mdu_timeout,
           stall_count, dbg_state
  );

endinterface

// File: rtl/pc_stall_controller_load_use_detector.sv
// Load-use hazard detector: flags when the instruction in decode reads
// the register that the load currently in EX is about to write.
// Register 0 is hard-wired to zero, so it never creates a hazard.
module pc_stall_controller_load_use_detector #(
  parameter int REG_W = 5
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_load_rt,
  input  logic             id_uses_rs,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  logic rs_match;
  logic rt_match;

  // Compare each source operand that decode actually reads against the load target.
  always_comb begin
    rs_match = id_uses_rs && (id_rs == ex_load_rt);
    rt_match = id_uses_rt && (id_rt == ex_load_rt);
    hazard   = ex_is_load && (ex_load_rt != '0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pc_stall_controller.sv
// PC / fetch / decode stall controller. Each cycle decides whether the PC
// holds, whether decode->EX gets a bubble and whether fetch/decode are
// flushed, based on I-mem readiness, load-use hazards, multi-cycle MDU
// operations and taken branches resolved in EX. Also keeps a sticky MDU
// timeout flag and a saturating count of PC-hold cycles.
module pc_stall_controller #(
  parameter int REG_W       = pc_stall_controller_pkg::REG_W,
  parameter int CNT_W       = 16,
  parameter int MDU_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  reset_n,
  pc_stall_controller_if.slave bus
);
  import pc_stall_controller_pkg::*;

  // Wide enough to hold MDU_TIMEOUT itself, where the counter parks.
  localparam int WAIT_W = $clog2(MDU_TIMEOUT + 1);

  state_t             state;
  state_t             state_nx;
  logic               load_use;
  logic               keep_pc;
  logic               id_bubble;
  logic               if_flush;
  logic               mdu_start;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mdu_timeout;
  logic [CNT_W-1:0]   stall_cnt;

  pc_stall_controller_load_use_detector #(
    .REG_W (REG_W)
  ) u_load_use_detector (
    .ex_is_load (bus.ex_is_load),
    .ex_load_rt (bus.ex_load_rt),
    .id_uses_rs (bus.id_uses_rs),
    .id_rs      (bus.id_rs),
    .id_uses_rt (bus.id_uses_rt),
    .id_rt      (bus.id_rt),
    .hazard     (load_use)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and same-cycle control outputs, highest priority first.
  // MDU_WAIT is resolved before everything else: the in-flight MDU op is
  // older than anything in EX, and mdu_done is a single pulse that must
  // not be lost to an I-mem stall in the same cycle.
  always_comb begin
    state_nx  = state;
    keep_pc   = 1'b0;
    id_bubble = 1'b0;
    if_flush  = 1'b0;
    mdu_start = 1'b0;
    if (state == ST_MDU_WAIT) begin
      if (bus.mdu_done) begin
        state_nx = ST_RUN;
      end else begin
        keep_pc   = 1'b1;
        id_bubble = 1'b1;
      end
    end else if (bus.branch_taken) begin
      if_flush  = 1'b1;
      id_bubble = 1'b1;
      state_nx  = ST_FLUSH;
    end else if (state == ST_FLUSH) begin
      // Decode holds a squashed instruction, so its hazards are meaningless.
      id_bubble = 1'b1;
      keep_pc   = !bus.imem_valid;
      state_nx  = ST_RUN;
    end else if (!bus.imem_valid) begin
      keep_pc   = 1'b1;
      id_bubble = 1'b1;
    end else if (state == ST_LOAD_STALL) begin
      // The single stall cycle has elapsed; the load result now forwards.
      state_nx = ST_RUN;
    end else if (bus.id_is_mdu) begin
      mdu_start = 1'b1;
      keep_pc   = 1'b1;
      id_bubble = 1'b1;
      state_nx  = ST_MDU_WAIT;
    end else if (load_use) begin
      keep_pc   = 1'b1;
      id_bubble = 1'b1;
      state_nx  = ST_LOAD_STALL;
    end
  end

  // MDU wait-cycle counter and sticky timeout flag. The counter restarts on
  // every entry to MDU_WAIT and parks at MDU_TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      mdu_timeout <= 1'b0;
    end else if (state != ST_MDU_WAIT && state_nx == ST_MDU_WAIT) begin
      wait_cnt <= '0;
    end else if (state == ST_MDU_WAIT && !bus.mdu_done &&
                 wait_cnt != WAIT_W'(MDU_TIMEOUT)) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WAIT_W'(MDU_TIMEOUT - 1)) begin
        mdu_timeout <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (keep_pc && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.keep_pc     = keep_pc;
  assign bus.id_bubble   = id_bubble;
  assign bus.if_flush    = if_flush;
  assign bus.mdu_start   = mdu_start;
  assign bus.mdu_timeout = mdu_timeout;
  assign bus.stall_count = stall_cnt;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_pc_stall_controller.sv
// Testbench for pc_stall_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the stall rules.
module tb_pc_stall_controller;

  localparam int REG_W       = 5;
  localparam int CNT_W       = 8;
  localparam int MDU_TIMEOUT = 64;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;

  int n_cmp = 0;
  int n_err = 0;

  pc_stall_controller_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pc_stall_controller #(
    .REG_W       (REG_W),
    .CNT_W       (CNT_W),
    .MDU_TIMEOUT (MDU_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which pending situation the pipeline is in, plus counters.
  bit m_flush_pending;   // previous cycle squashed fetch/decode
  bit m_load_pending;    // previous cycle inserted the load-use stall
  bit m_mdu_busy;        // an MDU op is in flight
  int m_wait;            // MDU cycles waited so far
  bit m_tmo;
  int m_stalls;

  bit e_keep, e_bub, e_flush, e_start, hz;

  task automatic model_reset();
    m_flush_pending = 0;
    m_load_pending  = 0;
    m_mdu_busy      = 0;
    m_wait          = 0;
    m_tmo           = 0;
    m_stalls        = 0;
  endtask

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_reset();
      check("rst_timeout", 32'(bus.mdu_timeout), 0);
      check("rst_stall_count", 32'(bus.stall_count), 0);
    end else begin
      e_keep = 0; e_bub = 0; e_flush = 0; e_start = 0;
      hz = bus.ex_is_load && (bus.ex_load_rt != 0) &&
           ((bus.id_uses_rs && bus.id_rs == bus.ex_load_rt) ||
            (bus.id_uses_rt && bus.id_rt == bus.ex_load_rt));
      check("model_timeout", 32'(bus.mdu_timeout), 32'(m_tmo));
      check("model_stall_count", 32'(bus.stall_count), 32'(m_stalls));
      if (m_mdu_busy) begin
        if (bus.mdu_done) begin
          m_mdu_busy = 0;
        end else begin
          e_keep = 1; e_bub = 1;
          m_wait++;
          if (m_wait >= MDU_TIMEOUT) m_tmo = 1;
        end
      end else if (bus.branch_taken) begin
        e_flush = 1; e_bub = 1;
        m_flush_pending = 1;
        m_load_pending  = 0;
      end else if (m_flush_pending) begin
        e_bub = 1; e_keep = !bus.imem_valid;
        m_flush_pending = 0;
      end else if (!bus.imem_valid) begin
        e_keep = 1; e_bub = 1;
      end else if (m_load_pending) begin
        m_load_pending = 0;
      end else if (bus.id_is_mdu) begin
        e_start = 1; e_keep = 1; e_bub = 1;
        m_mdu_busy = 1;
        m_wait = 0;
      end else if (hz) begin
        e_keep = 1; e_bub = 1;
        m_load_pending = 1;
      end
      check("model_keep_pc", 32'(bus.keep_pc), 32'(e_keep));
      check("model_id_bubble", 32'(bus.id_bubble), 32'(e_bub));
      check("model_if_flush", 32'(bus.if_flush), 32'(e_flush));
      check("model_mdu_start", 32'(bus.mdu_start), 32'(e_start));
      if (e_keep && m_stalls < CNT_MAX) m_stalls++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.imem_valid   = 1'b1;
    bus.id_rs        = '0;
    bus.id_rt        = '0;
    bus.id_uses_rs   = 1'b0;
    bus.id_uses_rt   = 1'b0;
    bus.id_is_mdu    = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.ex_load_rt   = '0;
    bus.branch_taken = 1'b0;
    bus.mdu_done     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drive_random();
    bus.imem_valid   = ($urandom_range(0, 99) < 85);
    bus.id_rs        = REG_W'($urandom_range(0, 3));
    bus.id_rt        = REG_W'($urandom_range(0, 3));
    bus.id_uses_rs   = 1'($urandom_range(0, 1));
    bus.id_uses_rt   = 1'($urandom_range(0, 1));
    bus.id_is_mdu    = ($urandom_range(0, 11) == 0);
    bus.ex_is_load   = ($urandom_range(0, 2) == 0);
    bus.ex_load_rt   = REG_W'($urandom_range(0, 3));
    // A taken branch cannot resolve while an MDU op holds EX bubbled.
    bus.branch_taken = !m_mdu_busy && ($urandom_range(0, 9) == 0);
    bus.mdu_done     = m_mdu_busy && ($urandom_range(0, 7) == 0);
  endtask

  // ---------------- stimulus ----------------
  int keep_cycles;

  initial begin
    reset_n = 1'b0;
    set_idle();
    apply_reset();

    // Reset state with idle inputs.
    #1;
    check("reset_keep_pc", 32'(bus.keep_pc), 0);
    check("reset_id_bubble", 32'(bus.id_bubble), 0);
    check("reset_if_flush", 32'(bus.if_flush), 0);
    check("reset_mdu_start", 32'(bus.mdu_start), 0);
    check("reset_stall_count", 32'(bus.stall_count), 0);
    tick();

    // Load r5 in EX, decode reads rs=5: one stall, then no re-check.
    bus.ex_is_load = 1; bus.ex_load_rt = 5; bus.id_uses_rs = 1; bus.id_rs = 5;
    #1;
    check("lu_r5_keep", 32'(bus.keep_pc), 1);
    check("lu_r5_bubble", 32'(bus.id_bubble), 1);
    tick();
    #1;
    check("lu_r5_after_keep", 32'(bus.keep_pc), 0);
    check("lu_r5_after_bubble", 32'(bus.id_bubble), 0);
    tick();
    set_idle();

    // Load r0 never stalls.
    bus.ex_is_load = 1; bus.ex_load_rt = 0; bus.id_uses_rs = 1; bus.id_rs = 0;
    #1;
    check("lu_r0_keep", 32'(bus.keep_pc), 0);
    tick();

    // Hazard through rt only.
    set_idle();
    bus.ex_is_load = 1; bus.ex_load_rt = 3; bus.id_uses_rt = 1; bus.id_rt = 3;
    #1;
    check("lu_rt_keep", 32'(bus.keep_pc), 1);
    tick();
    set_idle();
    tick();

    // MDU op completing after 10 wait cycles: 11 held cycles in total.
    apply_reset();
    keep_cycles = 0;
    bus.id_is_mdu = 1;
    #1;
    check("mdu_start_pulse", 32'(bus.mdu_start), 1);
    keep_cycles += int'(bus.keep_pc);
    tick();
    for (int k = 0; k < 10; k++) begin
      keep_cycles += int'(bus.keep_pc);
      tick();
    end
    bus.mdu_done = 1; bus.id_is_mdu = 0;
    #1;
    check("mdu_done_keep", 32'(bus.keep_pc), 0);
    tick();
    bus.mdu_done = 0;
    #1;
    check("mdu_keep_cycles", 32'(keep_cycles), 11);
    check("mdu_stall_count", 32'(bus.stall_count), 11);
    tick();

    // MDU op with no completion: timeout after 64 wait cycles, sticky.
    apply_reset();
    bus.id_is_mdu = 1;
    tick();
    bus.id_is_mdu = 0;
    for (int k = 1; k <= MDU_TIMEOUT; k++) begin
      if (k == MDU_TIMEOUT) begin
        #1;
        check("tmo_before", 32'(bus.mdu_timeout), 0);
        check("tmo_before_count", 32'(bus.stall_count), 64);
      end
      tick();
    end
    #1;
    check("tmo_set", 32'(bus.mdu_timeout), 1);
    check("tmo_set_count", 32'(bus.stall_count), 65);
    repeat (5) tick();
    check("tmo_count_rising", 32'(bus.stall_count), 70);
    bus.mdu_done = 1;
    tick();
    bus.mdu_done = 0;
    #1;
    check("tmo_sticky", 32'(bus.mdu_timeout), 1);
    check("tmo_run_keep", 32'(bus.keep_pc), 0);
    tick();

    // Taken branch together with a load-use hazard.
    apply_reset();
    bus.ex_is_load = 1; bus.ex_load_rt = 7; bus.id_uses_rs = 1; bus.id_rs = 7;
    bus.branch_taken = 1;
    #1;
    check("br_flush", 32'(bus.if_flush), 1);
    check("br_keep", 32'(bus.keep_pc), 0);
    check("br_bubble", 32'(bus.id_bubble), 1);
    tick();
    bus.branch_taken = 0;
    #1;
    check("flush_state_flush", 32'(bus.if_flush), 0);
    check("flush_state_bubble", 32'(bus.id_bubble), 1);
    check("flush_state_keep", 32'(bus.keep_pc), 0);
    tick();
    #1;
    check("flush_back_to_run", 32'(bus.keep_pc), 1);
    tick();
    set_idle();
    tick();

    // I-mem not ready for three cycles, then a reset pulse.
    apply_reset();
    bus.imem_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("imem_keep", 32'(bus.keep_pc), 1);
      tick();
    end
    bus.imem_valid = 1;
    #1;
    check("imem_stall_count", 32'(bus.stall_count), 3);
    check("imem_release_keep", 32'(bus.keep_pc), 0);
    reset_n = 0;
    #1;
    check("pulse_stall_count", 32'(bus.stall_count), 0);
    check("pulse_keep", 32'(bus.keep_pc), 0);
    tick();
    reset_n = 1;
    tick();

    // Stall counter saturates at all-ones.
    bus.imem_valid = 0;
    repeat (CNT_MAX + 5) tick();
    check("sat_count", 32'(bus.stall_count), CNT_MAX);
    bus.imem_valid = 1;
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_idle();
        reset_n = 0;
        tick();
        reset_n = 1;
      end
      drive_random();
      tick();
    end

    set_idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
